// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants and the ALU-control field bundle shared by decode and execute.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 shared by SRLI/SRAI (and SRL/SRA); instr[30] picks arithmetic.
  localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

  // Control fields handed to the ALU alongside the two operands and the PC.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct1;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [11:0] imm12;
    logic [19:0] u_imm20;
  } alu_ctrl_t;

  // Subtract / arithmetic-shift select. Only register ops and the immediate
  // right shifts honour instr[30]; ADDI/ANDI/ORI/XORI etc. carry immediate
  // bits there and must never turn into a subtract.
  function automatic logic sub_select(input logic [6:0] opcode,
                                      input logic [2:0] funct3,
                                      input logic       bit30);
    logic sel;
    sel = 1'b0;
    if (opcode == OPC_OP) begin
      sel = bit30;
    end else if (opcode == OPC_OP_IMM && funct3 == F3_SHIFT_RIGHT) begin
      sel = bit30;
    end
    return sel;
  endfunction

  // Slice an instruction word into the ALU control fields.
  function automatic alu_ctrl_t decode_ctrl(input logic [31:0] instr);
    alu_ctrl_t c;
    c.opcode  = instr[6:0];
    c.funct3  = instr[14:12];
    c.rd      = instr[11:7];
    c.rs2     = instr[24:20];
    c.u_imm20 = instr[31:12];
    c.imm12   = (instr[6:0] == OPC_STORE) ? {instr[31:25], instr[11:7]} : instr[31:20];
    c.funct1  = sub_select(instr[6:0], instr[14:12], instr[30]);
    return c;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: integer register file, two combinational read ports, one write port, x0 reads zero.
// Latency: reads are asynchronous; a write is visible to reads after the clock edge it is sampled on.
// Backpressure: none, a write is always taken.
module regfile_2r1w #(
  parameter int XLEN          = 32,
  parameter int NREGS         = 32,
  parameter bit RESET_REGFILE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs1_idx,
  output logic [XLEN-1:0]          rs1_data,
  input  logic [$clog2(NREGS)-1:0] rs2_idx,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_idx,
  input  logic [XLEN-1:0]          wr_data
);

  logic [XLEN-1:0] mem [NREGS];

  // Write port; x0 is never stored so it needs no special read-side masking beyond the index check.
  always_ff @(posedge clk) begin
    if (reset && RESET_REGFILE) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_idx != '0) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rs1_data = (rs1_idx == '0) ? '0 : mem[rs1_idx];
  assign rs2_data = (rs2_idx == '0) ? '0 : mem[rs2_idx];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode plus ID/EX register feeding the ALU; owns the register file.
// Latency: 1 cycle from accept to out_valid; writeback lands in the register file on its own edge.
// Backpressure: in_ready = !out_valid || out_ready; stalled outputs hold, held operands track writeback.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NREGS         = 32,
  parameter bit RESET_REGFILE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [19:0]     out_u_imm20,
  output logic [11:0]     out_imm12,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct1,
  output logic [4:0]      out_rd
);

  logic            valid_q;
  alu_ctrl_t       ctrl_d;
  alu_ctrl_t       ctrl_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [4:0]      rs1_idx_q;
  logic [4:0]      rs2_idx_q;

  logic [4:0]      rs1_sel;
  logic [4:0]      rs2_sel;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            wb_live;
  logic            accept;
  logic            load;
  logic            stall;

  assign rs1_sel = in_instr[19:15];
  assign rs2_sel = in_instr[24:20];
  assign ctrl_d  = decode_ctrl(in_instr);

  // Reset forces ready so fetch never sees a stuck stage coming out of reset.
  assign in_ready = reset || !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && !flush;
  assign stall    = valid_q && !out_ready;
  assign wb_live  = wb_en && (wb_rd != 5'd0);

  regfile_2r1w #(
    .XLEN          (XLEN),
    .NREGS         (NREGS),
    .RESET_REGFILE (RESET_REGFILE)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_idx  (rs1_sel),
    .rs1_data (rf_rs1),
    .rs2_idx  (rs2_sel),
    .rs2_data (rf_rs2),
    .wr_en    (wb_en),
    .wr_idx   (wb_rd),
    .wr_data  (wb_data)
  );

  // Same-edge writeback wins over the stale array value so the captured operand is never one write behind.
  always_comb begin
    rs1_fwd = rf_rs1;
    rs2_fwd = rf_rs2;
    if (wb_live && wb_rd == rs1_sel) rs1_fwd = wb_data;
    if (wb_live && wb_rd == rs2_sel) rs2_fwd = wb_data;
  end

  // Output valid: flush beats accept, accept beats consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Payload capture on accept; while stalled, held operands follow writes to their source registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
    end else if (load) begin
      ctrl_q     <= ctrl_d;
      pc_q       <= in_pc;
      rs1_data_q <= rs1_fwd;
      rs2_data_q <= rs2_fwd;
      rs1_idx_q  <= rs1_sel;
      rs2_idx_q  <= rs2_sel;
    end else if (stall) begin
      if (wb_live && wb_rd == rs1_idx_q) rs1_data_q <= wb_data;
      if (wb_live && wb_rd == rs2_idx_q) rs2_data_q <= wb_data;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_u_imm20  = ctrl_q.u_imm20;
  assign out_imm12    = ctrl_q.imm12;
  assign out_rs2      = ctrl_q.rs2;
  assign out_opcode   = ctrl_q.opcode;
  assign out_funct3   = ctrl_q.funct3;
  assign out_funct1   = ctrl_q.funct1;
  assign out_rd       = ctrl_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed literal checks plus randomized traffic against a behavioural model.
// Latency: model expects decoded fields one edge after accept.
// Backpressure: out_ready and flush are randomized; model tracks held instruction and register file.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [19:0] out_u_imm20;
  logic [11:0] out_imm12;
  logic [4:0]  out_rs2;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct1;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32), .NREGS(32), .RESET_REGFILE(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_u_imm20  (out_u_imm20),
    .out_imm12    (out_imm12),
    .out_rs2      (out_rs2),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct1   (out_funct1),
    .out_rd       (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: a register array, plus at most one held instruction word.
  // While an instruction is held its operands are simply the current register values.
  logic [31:0] rf [32];
  logic        m_valid;
  logic        m_zero;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        started = 1'b0;

  function automatic logic exp_funct1(input logic [31:0] i);
    if (i[6:0] == 7'b0110011) return i[30];
    if (i[6:0] == 7'b0010011 && i[14:12] == 3'b101) return i[30];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic acc;
    started = 1'b1;
    if (reset) begin
      m_valid = 1'b0;
      m_zero  = 1'b1;
      m_instr = '0;
      m_pc    = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (wb_en && wb_rd != 5'd0) rf[wb_rd] = wb_data;
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
        m_zero  = 1'b0;
        m_instr = in_instr;
        m_pc    = in_pc;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: every falling edge once the model has seen an edge.
  always @(negedge clk) begin
    logic [31:0] i;
    if (started) begin
      check("in_ready", in_ready, reset || !m_valid || out_ready);
      check("out_valid", out_valid, m_valid);
      if (m_zero) begin
        check("zero_fields", {out_pc, out_rs1_data, out_rs2_data}, 96'h0);
        check("zero_ctrl", {out_u_imm20, out_imm12, out_rs2, out_opcode, out_funct3, out_funct1, out_rd}, 53'h0);
      end else if (m_valid) begin
        i = m_instr;
        check("pc", out_pc, m_pc);
        check("rs1_data", out_rs1_data, rf[i[19:15]]);
        check("rs2_data", out_rs2_data, rf[i[24:20]]);
        check("u_imm20", out_u_imm20, i[31:12]);
        check("imm12", out_imm12, (i[6:0] == 7'b0100011) ? {i[31:25], i[11:7]} : i[31:20]);
        check("rs2", out_rs2, i[24:20]);
        check("opcode", out_opcode, i[6:0]);
        check("funct3", out_funct3, i[14:12]);
        check("funct1", out_funct1, exp_funct1(i));
        check("rd", out_rd, i[11:7]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one edge (caller guarantees in_ready), then stop at the falling edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
    wb_en    = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      4: w[6:0] = 7'b0110111;
      5: w[6:0] = 7'b0010111;
      6: w[6:0] = 7'b1100011;
      7: w[6:0] = 7'b1101111;
      8: w[6:0] = 7'b1100111;
      default: ;
    endcase
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 0) w[14:12] = 3'b101;
    return w;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("lit_reset_valid", out_valid, 1'b0);
    check("lit_reset_in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;
    check("lit_post_reset_in_ready", in_ready, 1'b1);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    tick();
    wb_en = 1'b0;

    // add x3,x5,x0
    issue(32'h000281B3, 32'h0000_0100);
    check("lit_add_valid", out_valid, 1'b1);
    check("lit_add_rs1", out_rs1_data, 32'h0000_1234);
    check("lit_add_rs2", out_rs2_data, 32'h0);
    check("lit_add_funct1", out_funct1, 1'b0);
    check("lit_add_rd", out_rd, 5'd3);
    check("lit_add_pc", out_pc, 32'h0000_0100);
    tick(); issue(32'h403100B3, 32'h104);   // sub x1,x2,x3
    check("lit_sub_funct1", out_funct1, 1'b1);
    tick(); issue(32'hC0000093, 32'h108);   // addi x1,x0,-1024
    check("lit_addi_imm12", out_imm12, 12'hC00);
    check("lit_addi_funct1", out_funct1, 1'b0);
    tick(); issue(32'h40315093, 32'h10C);   // srai x1,x2,3
    check("lit_srai_funct1", out_funct1, 1'b1);
    check("lit_srai_rs2", out_rs2, 5'd3);
    tick(); issue(32'h00612423, 32'h110);   // sw x6,8(x2)
    check("lit_sw_imm12", out_imm12, 12'h008);
    check("lit_sw_opcode", out_opcode, 7'h23);
    tick(); issue(32'hABCDE0B7, 32'h114);   // lui x1,0xABCDE
    check("lit_lui_u", out_u_imm20, 20'hABCDE);

    // Stall with add x1,x7,x0 pending; write x7 underneath it.
    tick(); out_ready = 1'b0;
    issue(32'h000380B3, 32'h200);
    check("lit_stall_in_ready", in_ready, 1'b0);
    tick();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    in_valid = 1'b1; in_instr = 32'h403100B3; in_pc = 32'h204;
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("lit_refresh_rs1", out_rs1_data, 32'hDEAD_BEEF);
    check("lit_refresh_pc", out_pc, 32'h200);
    check("lit_refresh_rd", out_rd, 5'd1);
    check("lit_refresh_valid", out_valid, 1'b1);
    tick(); out_ready = 1'b1;

    // Same-edge bypass: write x9 while accepting add x2,x9,x9.
    tick();
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hCAFE_0009;
    issue(32'h00948133, 32'h300);
    check("lit_bypass_rs1", out_rs1_data, 32'hCAFE_0009);
    check("lit_bypass_rs2", out_rs2_data, 32'hCAFE_0009);

    // Writes to x0 never stick, even when bypass would match.
    tick();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue(32'h00000233, 32'h304);
    check("lit_x0_bypass", out_rs1_data, 32'h0);
    tick(); issue(32'h00000233, 32'h308);
    check("lit_x0_read", out_rs2_data, 32'h0);

    // Flush together with an accept.
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h000281B3;
    #1 check("lit_flush_in_ready", in_ready, 1'b1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("lit_flush_valid", out_valid, 1'b0);

    // Reset while stalled drops everything.
    tick(); out_ready = 1'b0;
    issue(32'hABCDE0B7, 32'h400);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("lit_rst_valid", out_valid, 1'b0);
    check("lit_rst_pc", out_pc, 32'h0);
    check("lit_rst_u", out_u_imm20, 20'h0);
    check("lit_rst_opcode", out_opcode, 7'h0);
    tick(); out_ready = 1'b1;

    // Randomized traffic; small register window makes bypass/refresh hits common.
    for (int n = 0; n < 2000; n++) begin
      tick();
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
    end
    tick();
    in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0; reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage and ID/EX pipeline register, directly upstream of the 32-bit ALU top level.
- Accepts a fetched instruction and its PC over a valid/ready handshake, and reads the 32x32 integer register file (held internally).
- Splits the instruction into the ALU's operand and control fields and presents them registered, with the same valid/ready handshake, to the execute stage.
- Owns the register-file write port driven by writeback.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, architectural register count (x0 hardwired zero)
RESET_REGFILE, 1, 1 = synchronous reset clears every register to 0; 0 = register contents untouched by reset

Ports:
clk  input  1  sole clock, all state updates on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  32  RV32I instruction word
in_pc  input  XLEN  PC of in_instr
flush  input  1  kill held/incoming instruction (branch redirect)
wb_en  input  1  register-file write enable
wb_rd  input  5  write index
wb_data  input  XLEN  write data
out_valid  output  1  decoded instruction available
out_ready  input  1  execute consumes this cycle
out_pc  output  XLEN  registered PC
out_rs1_data  output  XLEN  rs1 operand
out_rs2_data  output  XLEN  rs2 operand
out_u_imm20  output  20  instr[31:12]
out_imm12  output  12  I-type instr[31:20]; S-type (opcode 0100011) {instr[31:25],instr[11:7]}
out_rs2  output  5  instr[24:20] (shift amount for immediate shifts)
out_opcode  output  7  instr[6:0]
out_funct3  output  3  instr[14:12]
out_funct1  output  1  sub/arith-shift select, see below
out_rd  output  5  instr[11:7]

Behaviour:
- Reset: out_valid=0; all out_* data fields=0; internal rs1/rs2 index copies=0; register file cleared when RESET_REGFILE=1.
- in_ready = !out_valid || out_ready (combinational). in_ready is 1 while reset is asserted and in the cycle after.
- Accept occurs when in_valid && in_ready. The decoded fields load on that edge and out_valid=1 the next cycle: latency 1.
- If out_valid && out_ready && !accept, out_valid clears next cycle.
- If out_valid && !out_ready, all outputs are held stable (except operand refresh below).
- flush has priority over accept. flush=1 forces out_valid=0 next cycle and discards any same-cycle accepted instruction. in_ready is unaffected by flush.
- out_funct1:
  - opcode 0110011 (OP): instr[30].
  - opcode 0010011 (OP-IMM) with funct3=101: instr[30].
  - All other cases: 0. ADDI and the logic immediates must never subtract.
- Register file: x0 reads 0; writes to x0 are ignored.
- Same-cycle write/read bypass: if wb_en && wb_rd!=0 && wb_rd matches the rs1/rs2 index being read at accept, the captured operand = wb_data.
- Stalled refresh: while out_valid && !out_ready, a writeback with wb_rd!=0 matching the held rs1 (rs2) index overwrites out_rs1_data (out_rs2_data) on that edge.
- Writeback and decode are independent: writes proceed during stall, flush and idle.
- Reset mid-operation drops the held instruction. No partial state survives.

Decomposition:
- Shared package decode_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, LUI, AUIPC, BRANCH, JAL, JALR) and the ALU-control field struct also used by execute.
- Sub-module regfile_2r1w: 2 async read ports, 1 sync write port, x0 zero, optional reset.
- Bypass and refresh logic live in decode_stage.

Test Plan:
- Reset, then write x5=0x0000_1234 via wb, then issue add x3,x5,x0 (0x000281B3) with out_ready=1 → one cycle later out_valid=1, out_rs1_data=0x1234, out_rs2_data=0, out_funct1=0, out_rd=3.
- sub x1,x2,x3 (0x403100B3) → out_funct1=1. addi x1,x0,-1024 (0xC0000093) → out_imm12=0xC00, out_funct1=0. srai x1,x2,3 (0x40315093) → out_funct1=1, out_rs2=3.
- sw x6,8(x2) (0x00612423) → out_imm12=0x008, out_opcode=0x23. lui x1,0xABCDE (0xABCDE0B7) → out_u_imm20=0xABCDE.
- Hold out_ready=0 with an add of x7 pending, then wb x7=0xDEAD_BEEF → in_ready=0, held outputs stable except out_rs1_data becomes 0xDEADBEEF, plus same-cycle accept bypass check. Writes to x0 → x0 still reads 0.
- Assert flush together with in_valid=1 and in_ready=1 → next cycle out_valid=0. Reset asserted while an instruction is stalled → out_valid=0 and all outputs 0 next cycle.
